// File: rtl/rx_frame_deframer.sv
// Receive deframer: hunts SOF in the RX FWFT FIFO, validates length/checksum/trailer,
// streams payload with valid/ready. Optional checksum word enabled by RX_CHECKSUM_EN.
module rx_frame_deframer (
  input  logic        clk160,
  input  logic        rst,
  input  logic [15:0] i_fifo_dout,
  input  logic        i_fifo_valid,
  output logic        o_fifo_rd,
  output logic [15:0] o_dataout,
  output logic        o_dataout_valid,
  output logic        o_dataout_sof,
  output logic        o_dataout_eof,
  input  logic        i_dataout_ready,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_frame_count,
  output logic [15:0] o_err_count
);

  localparam int unsigned W_DATA = 16;
  localparam int unsigned W_LEN  = 8;
  localparam int unsigned W_STAT = 16;

  localparam logic [W_DATA-1:0] SOF_WORD = 16'hBC3C;
  localparam logic [W_DATA-1:0] EOF_WORD = 16'hBCFD;
  localparam logic [W_LEN-1:0]  MAX_LEN  = 8'd128;
  localparam logic [W_STAT-1:0] STAT_MAX = 16'hFFFF;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_EOF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
`ifdef RX_CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_TRL  = 3'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [W_LEN-1:0]   r_cnt;
  logic               r_first;
  logic [W_DATA-1:0]  r_dout;
  logic               r_dout_valid;
  logic               r_sof;
  logic               r_eof;
  logic               r_ok;
  logic               r_err;
  logic [1:0]         r_err_code;
  logic [W_STAT-1:0]  r_frame_count;
  logic [W_STAT-1:0]  r_err_count;

  logic               w_pop;
  logic               w_hdr_load;
  logic               w_pay_load;
  logic               w_ok_set;
  logic               w_err_set;
  logic [1:0]         w_err_code;
  logic [W_LEN-1:0]   w_len;
  logic               w_mismatch;

`ifdef RX_CHECKSUM_EN
  logic [W_DATA-1:0]  r_acc;
  logic               r_mismatch;
  logic               w_chk_pop;

  assign w_mismatch = r_mismatch;
`else
  assign w_mismatch = 1'b0;
`endif

  assign w_len = i_fifo_dout[W_LEN-1:0];

  // Only payload pops are throttled by the downstream register
  assign w_pop = i_fifo_valid &&
                 ((r_state != S_PAY) || !r_dout_valid || i_dataout_ready);

  assign o_fifo_rd = w_pop;

  // State register
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-pop strobes; nothing advances without a consumed word
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_load  = 1'b0;
    w_pay_load  = 1'b0;
    w_ok_set    = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = ERR_NONE;
`ifdef RX_CHECKSUM_EN
    w_chk_pop   = 1'b0;
`endif
    if (w_pop) begin
      unique case (r_state)
        S_IDLE: begin
          if (i_fifo_dout == SOF_WORD) begin
            w_state_nxt = S_HDR;
          end
        end
        S_HDR: begin
          if ((w_len == 8'd0) || (w_len > MAX_LEN)) begin
            w_err_set   = 1'b1;
            w_err_code  = ERR_LEN;
            w_state_nxt = S_IDLE;
          end else begin
            w_hdr_load  = 1'b1;
            w_state_nxt = S_PAY;
          end
        end
        S_PAY: begin
          w_pay_load = 1'b1;
          if (r_cnt == 8'd1) begin
`ifdef RX_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_TRL;
`endif
          end
        end
`ifdef RX_CHECKSUM_EN
        S_CHK: begin
          w_chk_pop   = 1'b1;
          w_state_nxt = S_TRL;
        end
`endif
        S_TRL: begin
          w_state_nxt = S_IDLE;
          if (i_fifo_dout != EOF_WORD) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_EOF;
          end else if (w_mismatch) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_CHK;
          end else begin
            w_ok_set   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Payload down-counter and first-word marker
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (w_hdr_load) begin
      r_cnt   <= w_len;
      r_first <= 1'b1;
    end else if (w_pay_load) begin
      r_cnt   <= r_cnt - 8'd1;
      r_first <= 1'b0;
    end
  end

  // Output register: held while valid and not ready
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
    end else if (w_pay_load) begin
      r_dout       <= i_fifo_dout;
      r_dout_valid <= 1'b1;
      r_sof        <= r_first;
      r_eof        <= (r_cnt == 8'd1);
    end else if (i_dataout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  // Status pulses, sticky error code and saturating statistics
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_ok          <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_ok  <= w_ok_set;
      r_err <= w_err_set;
      if (w_err_set) begin
        r_err_code <= w_err_code;
        if (r_err_count != STAT_MAX) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
      if (w_ok_set && (r_frame_count != STAT_MAX)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  // Running XOR over header and payload, compared against the checksum word
  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_hdr_load) begin
        r_acc <= i_fifo_dout;
      end else if (w_pay_load) begin
        r_acc <= r_acc ^ i_fifo_dout;
      end
      if (w_chk_pop) begin
        r_mismatch <= (i_fifo_dout != r_acc);
      end
    end
  end
`endif

  assign o_dataout       = r_dout;
  assign o_dataout_valid = r_dout_valid;
  assign o_dataout_sof   = r_sof;
  assign o_dataout_eof   = r_eof;
  assign o_frame_ok      = r_ok;
  assign o_frame_err     = r_err;
  assign o_err_code      = r_err_code;
  assign o_frame_count   = r_frame_count;
  assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Directed bench for rx_frame_deframer; a queue models the FWFT RX FIFO.
// Covers both builds (RX_CHECKSUM_EN defined or not).
module tb_rx_frame_deframer;

  logic        clk160 = 1'b0;
  logic        rst;
  logic [15:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_rd;
  logic [15:0] dataout;
  logic        dataout_valid;
  logic        dataout_sof;
  logic        dataout_eof;
  logic        dataout_ready;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ec   = 0;
  logic [15:0] q[$];

`ifdef RX_CHECKSUM_EN
  localparam int unsigned BP_LEFT = 4;
`else
  localparam int unsigned BP_LEFT = 3;
`endif

  always #5 clk160 = ~clk160;

  rx_frame_deframer dut (
    .clk160          (clk160),
    .rst             (rst),
    .i_fifo_dout     (fifo_dout),
    .i_fifo_valid    (fifo_valid),
    .o_fifo_rd       (fifo_rd),
    .o_dataout       (dataout),
    .o_dataout_valid (dataout_valid),
    .o_dataout_sof   (dataout_sof),
    .o_dataout_eof   (dataout_eof),
    .i_dataout_ready (dataout_ready),
    .o_frame_ok      (frame_ok),
    .o_frame_err     (frame_err),
    .o_err_code      (err_code),
    .o_frame_count   (frame_count),
    .o_err_count     (err_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: present FIFO head, capture pop decision before the edge, sample 1ns after
  task automatic tick();
    logic popped;
    fifo_valid = (q.size() != 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 16'h0000;
    #4;
    popped = fifo_rd;
    @(posedge clk160);
    #1;
    if (popped && q.size() != 0) q.delete(0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 64) begin
      tick();
      guard++;
    end
    if (q.size() != 0) chk(tag, 16'(q.size()), 16'd0);
  endtask

  task automatic push_good();
    q.push_back(16'hBC3C); q.push_back(16'h0003);
    q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333);
`ifdef RX_CHECKSUM_EN
    q.push_back(16'h0003);
`endif
    q.push_back(16'hBCFD);
  endtask

  initial begin
    rst = 1'b1; fifo_valid = 1'b0; fifo_dout = 16'h0000; dataout_ready = 1'b1;
    repeat (2) @(posedge clk160);
    #1;
    chk("rst_dout", dataout, 16'h0000);
    chk("rst_valid", 16'(dataout_valid), 16'd0);
    chk("rst_sof_eof", {14'd0, dataout_sof, dataout_eof}, 16'd0);
    chk("rst_pulses", {14'd0, frame_ok, frame_err}, 16'd0);
    chk("rst_err_code", 16'(err_code), 16'd0);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_ec", err_count, 16'd0);
    chk("rst_fifo_rd", 16'(fifo_rd), 16'd0);
    rst = 1'b0;

    // Good frame, ready high
    push_good();
    tick(); tick();
    chk("g_hdr_novalid", 16'(dataout_valid), 16'd0);
    tick();
    chk("g_w1", dataout, 16'h1111);
    chk("g_w1_flags", {13'd0, dataout_valid, dataout_sof, dataout_eof}, 16'b110);
    tick();
    chk("g_w2", dataout, 16'h2222);
    chk("g_w2_flags", {13'd0, dataout_valid, dataout_sof, dataout_eof}, 16'b100);
    tick();
    chk("g_w3", dataout, 16'h3333);
    chk("g_w3_flags", {13'd0, dataout_valid, dataout_sof, dataout_eof}, 16'b101);
    chk("g_no_ok_early", 16'(frame_ok), 16'd0);
    drain("g_drain");
    chk("g_ok", {14'd0, frame_ok, frame_err}, 16'b10);
    chk("g_fc", frame_count, 16'd1);
    chk("g_valid_clr", 16'(dataout_valid), 16'd0);
    tick();
    chk("g_ok_oneshot", 16'(frame_ok), 16'd0);

`ifdef RX_CHECKSUM_EN
    // Checksum error: payload still delivered
    q.push_back(16'hBC3C); q.push_back(16'h0003);
    q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333);
    q.push_back(16'h0004); q.push_back(16'hBCFD);
    tick(); tick(); tick();
    chk("cs_w1", dataout, 16'h1111);
    drain("cs_drain");
    exp_ec++;
    chk("cs_err", {14'd0, frame_ok, frame_err}, 16'b01);
    chk("cs_code", 16'(err_code), 16'd2);
    chk("cs_ec", err_count, 16'(exp_ec));
`endif

    // Bad lengths 0 and 0x81, then a good frame
    q.push_back(16'hBC3C); q.push_back(16'h0000);
    drain("l0_drain");
    exp_ec++;
    chk("l0_err", {14'd0, frame_ok, frame_err}, 16'b01);
    chk("l0_code", 16'(err_code), 16'd1);
    chk("l0_novalid", 16'(dataout_valid), 16'd0);
    q.push_back(16'hBC3C); q.push_back(16'h0081);
    drain("l81_drain");
    exp_ec++;
    chk("l81_err", 16'(frame_err), 16'd1);
    chk("l81_novalid", 16'(dataout_valid), 16'd0);
    chk("l81_ec", err_count, 16'(exp_ec));
    push_good();
    drain("l_good_drain");
    chk("l_good_ok", 16'(frame_ok), 16'd1);
    chk("l_good_fc", frame_count, 16'd2);
    chk("l_code_holds", 16'(err_code), 16'd1);

    // Missing EOF (payload word equal to SOF is plain data), junk, good frame
    q.push_back(16'hBC3C); q.push_back(16'h0001); q.push_back(16'hBC3C);
`ifdef RX_CHECKSUM_EN
    q.push_back(16'hBC3D);
`endif
    q.push_back(16'h1234);
    tick(); tick(); tick();
    chk("t_sofdata", dataout, 16'hBC3C);
    chk("t_sofdata_flags", {13'd0, dataout_valid, dataout_sof, dataout_eof}, 16'b111);
    drain("t_drain");
    exp_ec++;
    chk("t_err", {14'd0, frame_ok, frame_err}, 16'b01);
    chk("t_code", 16'(err_code), 16'd3);
    chk("t_ec", err_count, 16'(exp_ec));
    q.push_back(16'h5555);
    push_good();
    drain("t_good_drain");
    chk("t_good_ok", {14'd0, frame_ok, frame_err}, 16'b10);
    chk("t_good_fc", frame_count, 16'd3);

    // Backpressure for 5 cycles mid-payload
    q.push_back(16'hBC3C); q.push_back(16'h0004);
    q.push_back(16'hA001); q.push_back(16'hA002); q.push_back(16'hA003); q.push_back(16'hA004);
`ifdef RX_CHECKSUM_EN
    q.push_back(16'h0000);
`endif
    q.push_back(16'hBCFD);
    tick(); tick(); tick(); tick();
    chk("bp_w2", dataout, 16'hA002);
    dataout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", dataout, 16'hA002);
      chk("bp_valid", 16'(dataout_valid), 16'd1);
      chk("bp_rd_low", 16'(fifo_rd), 16'd0);
      chk("bp_qsize", 16'(q.size()), 16'(BP_LEFT));
    end
    dataout_ready = 1'b1;
    tick();
    chk("bp_w3", dataout, 16'hA003);
    chk("bp_w3_flags", {13'd0, dataout_valid, dataout_sof, dataout_eof}, 16'b100);
    tick();
    chk("bp_w4", dataout, 16'hA004);
    chk("bp_w4_eof", 16'(dataout_eof), 16'd1);
    drain("bp_drain");
    chk("bp_ok", 16'(frame_ok), 16'd1);
    chk("bp_fc", frame_count, 16'd4);

    // Reset mid-frame, then a good frame
    q.push_back(16'hBC3C); q.push_back(16'h0003); q.push_back(16'h1111); q.push_back(16'h2222);
    tick(); tick(); tick(); tick();
    chk("r_w2", dataout, 16'h2222);
    rst = 1'b1;
    #1;
    q.delete();
    chk("r_async_valid", 16'(dataout_valid), 16'd0);
    chk("r_async_fc", frame_count, 16'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("r_no_pulse", {14'd0, frame_ok, frame_err}, 16'b00);
    chk("r_fc0", frame_count, 16'd0);
    chk("r_ec0", err_count, 16'd0);
    chk("r_code0", 16'(err_code), 16'd0);
    push_good();
    drain("r_good_drain");
    chk("r_good_ok", {14'd0, frame_ok, frame_err}, 16'b10);
    chk("r_good_fc", frame_count, 16'd1);
    chk("r_good_ec", err_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_deframer.md
# rx_frame_deframer

Receive-direction deframer in the clk160 domain. It drains 16-bit words from the first-word-fall-through read port of the RX clock-crossing FIFO and hunts for frame delimiters. It validates length, checksum and trailer, and streams payload words downstream with a valid/ready handshake. It is the receive-side counterpart of the TX FIFO path that feeds the transceiver, and reports per-frame status and saturating statistics.

## Interface
- SOF_WORD, 16'hBC3C, start-of-frame delimiter
- EOF_WORD, 16'hBCFD, end-of-frame delimiter
- MAX_LEN, 8'd128, largest legal payload length in words
- clk160  in  1  system clock; all logic single-domain
- rst  in  1  asynchronous, active-high reset
- fifo_dout  in  16  FWFT RX FIFO head word
- fifo_valid  in  1  fifo_dout holds a valid word
- fifo_rd  out  1  pop request, combinational
- dataout  out  16  payload word
- dataout_valid  out  1  dataout qualified
- dataout_sof  out  1  qualifies first payload word of a frame
- dataout_eof  out  1  qualifies last payload word of a frame
- dataout_ready  in  1  downstream accepts when high with dataout_valid
- frame_ok  out  1  one-cycle pulse, frame passed all checks
- frame_err  out  1  one-cycle pulse, frame rejected
- err_code  out  2  0 none, 1 bad length, 2 checksum, 3 missing EOF; holds until the next frame_err
- frame_count  out  16  good frames, saturates at 16'hFFFF
- err_count  out  16  rejected frames, saturates at 16'hFFFF

## Operation
- Frame layout: SOF_WORD; header (bits[7:0] = payload length N, bits[15:8] reserved); N payload words; checksum word; EOF_WORD.
- The checksum word is the XOR of the header and all payload words.
- FSM states: IDLE, HDR, PAY, CHK, TRL. Only FIFO word consumption advances the FSM.
- IDLE:
  - Non-SOF words are popped and discarded silently.
  - SOF_WORD moves to HDR.
- HDR:
  - N==0 or N>MAX_LEN: frame_err, err_code=1, return to IDLE.
  - Otherwise: load the 8-bit down-counter with N, set acc=header, go to PAY.
- PAY:
  - Each word is loaded into the output register and XORed into acc.
  - SOF is asserted on the first payload word and EOF on the word where the count reaches 1.
  - After the last word, go to CHK.
  - SOF/EOF values inside the payload are plain data.
- CHK:
  - Compare the word with acc and latch a mismatch flag. Go to TRL.
- TRL:
  - Word == EOF_WORD and no mismatch: frame_ok, frame_count+1.
  - Word == EOF_WORD with mismatch: frame_err, err_code=2.
  - Word != EOF_WORD: frame_err, err_code=3. The word is consumed, not re-hunted.
  - All cases return to IDLE.
- Every frame_err increments err_count. Both counters saturate.
- Payload already delivered is not retracted; rejection is signalled only through frame_err.
- Pop rule: fifo_rd = fifo_valid && (state!=PAY || !dataout_valid || dataout_ready).
- Output register:
  - A PAY pop loads dataout/sof/eof and sets dataout_valid.
  - Otherwise, dataout_ready clears dataout_valid.
  - dataout/sof/eof hold while valid && !ready.

## Timing
- Reset values:
  - dataout=0; dataout_valid, dataout_sof, dataout_eof, frame_ok, frame_err all 0.
  - err_code=0, counters=0, FSM in IDLE, acc=0.
  - fifo_rd is 0 because fifo_valid gates it.
- Latency: a payload word popped at edge k is presented at dataout after edge k.
- Throughput is 1 word/cycle with dataout_ready held high.
- Backpressure stalls popping only in PAY. Non-payload words are always popped when valid.
- frame_ok/frame_err are registered and assert for exactly one cycle after the edge that pops the trailer (or the bad header).
- Counters and err_code update on that same edge.
- fifo_valid low in any state: hold state, no pop, no timeout.
- rst mid-frame: immediate return to IDLE; the partial frame is dropped with no error pulse and no count.

## Configuration
- RX_CHECKSUM_EN defined:
  - Frames carry the checksum word and the CHK state exists.
  - err_code 2 is reachable.
- RX_CHECKSUM_EN undefined:
  - There is no checksum word; PAY goes directly to TRL.
  - acc and the mismatch logic are removed.
  - err_code 2 never occurs.

## Test plan
- Good frame, ready high: BC3C, 0003, 1111, 2222, 3333, 0003, BCFD.
  - Expect dataout 1111/2222/3333 on consecutive cycles, with sof on 1111 and eof on 3333.
  - Expect frame_ok pulse, frame_count=1.
- Same frame with checksum 0004: payload still delivered; frame_err pulse, err_code=2, err_count=1.
- Header 0000, and separately header 0081 with MAX_LEN=128: frame_err, err_code=1, no dataout_valid; the following good frame is accepted.
- Trailer 1234 instead of BCFD: frame_err, err_code=3. Junk 5555 in IDLE before the next SOF is ignored.
- dataout_ready low for 5 cycles mid-payload:
  - dataout stable, fifo_rd low, no word lost or duplicated.
  - Resumes in order after ready returns high.
- rst asserted after the second payload word, then a good frame: no status pulse for the aborted frame; counters 0 then frame_count=1.
